// File: rtl/if_id_queue_pkg.sv
// Shared defaults for the IF->ID instruction buffer.
package if_id_queue_pkg;

    localparam int unsigned PC_W_DEF     = 32;
    localparam int unsigned INST_W_DEF   = 32;
    localparam int unsigned DEPTH_DEF    = 4;
    // ADD x0,x0,x0: the bubble decode sees when nothing is valid.
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0033;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF->ID instruction buffer.
interface if_id_queue_if
    import if_id_queue_pkg::*;
#(
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              flush;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  flush_drop;

    // Pipeline side: fetch drives in_*, decode drives out_ready, branch unit drives flush.
    modport master (
        output in_valid, in_pc, in_inst, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_inst, count, flush_drop
    );

    // Queue side.
    modport slave (
        input  in_valid, in_pc, in_inst, out_ready, flush,
        output in_ready, out_valid, out_pc, out_inst, count, flush_drop
    );

endinterface

// File: rtl/if_id_queue.sv
// IF->ID instruction buffer: show-ahead FIFO of {inst,pc} with flush,
// NOP substitution on the decode side and optional empty-queue bypass.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned       PC_W     = PC_W_DEF,
    parameter int unsigned       INST_W   = INST_W_DEF,
    parameter int unsigned       DEPTH    = DEPTH_DEF,
    parameter bit                BYPASS   = 1'b0,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic          clk,
    input  logic          rst,
    if_id_queue_if.slave  q
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = PC_W + INST_W;

    logic [DEPTH-1:0][ENT_W-1:0] mem_q;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [CNT_W-1:0]            drop_q, drop_d;

    logic             empty, full, bypass_act, out_valid;
    logic             push, pop, wr_en, rd_en;
    logic [ENT_W-1:0] head;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign bypass_act = BYPASS && empty && !q.flush;
    assign head       = mem_q[rd_ptr_q];

    // in_ready depends only on registered occupancy, keeping fetch free of a comb loop.
    assign push  = q.in_valid & ~full;
    assign pop   = out_valid & q.out_ready;
    // A bypassed entry consumed in the same cycle never touches storage.
    assign wr_en = push & ~q.flush & ~(bypass_act & q.out_ready);
    assign rd_en = pop & ~empty;

    assign q.in_ready   = ~full;
    assign q.out_valid  = out_valid;
    assign q.count      = count_q;
    assign q.flush_drop = drop_q;

    // Decode-side view: stored head, bypassed fetch word, or a NOP bubble.
    always_comb begin
        out_valid  = 1'b0;
        q.out_pc   = '0;
        q.out_inst = NOP_INST;
        if (!empty) begin
            out_valid  = 1'b1;
            q.out_inst = head[ENT_W-1:PC_W];
            q.out_pc   = head[PC_W-1:0];
        end else if (bypass_act && q.in_valid) begin
            out_valid  = 1'b1;
            q.out_inst = q.in_inst;
            q.out_pc   = q.in_pc;
        end
    end

    // Pointer, occupancy and flush bookkeeping; flush overrides push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = count_q - CNT_W'(rd_en);
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Entry storage, unreset; stale contents are masked by occupancy.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {q.in_inst, q.in_pc};
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: one BYPASS=0 and one BYPASS=1 instance share
// identical stimulus and are each compared against a queue-based model.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0033;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_id_queue_if #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH)) bus0 ();
    if_id_queue_if #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH)) bus1 ();

    if_id_queue #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH), .BYPASS(1'b0), .NOP_INST(NOP))
        dut0 (.clk(clk), .rst(rst), .q(bus0.slave));
    if_id_queue #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH), .BYPASS(1'b1), .NOP_INST(NOP))
        dut1 (.clk(clk), .rst(rst), .q(bus1.slave));

    int checks = 0;
    int errors = 0;

    // Reference: per instance an ordered list of {pc,inst} and the last flush drop.
    logic [63:0] mq [2][$];
    int unsigned mdrop [2];

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic ordy, input logic fl);
        bus0.in_valid = v; bus0.in_pc = pc; bus0.in_inst = inst;
        bus0.out_ready = ordy; bus0.flush = fl;
        bus1.in_valid = v; bus1.in_pc = pc; bus1.in_inst = inst;
        bus1.out_ready = ordy; bus1.flush = fl;
    endtask

    function automatic logic [71:0] observe(input int k);
        if (k == 0)
            return {bus0.out_valid, bus0.in_ready, bus0.out_pc, bus0.out_inst,
                    bus0.count, bus0.flush_drop};
        return {bus1.out_valid, bus1.in_ready, bus1.out_pc, bus1.out_inst,
                bus1.count, bus1.flush_drop};
    endfunction

    // One clock: compare both DUTs to the model mid-cycle, advance the model, cross the edge.
    task automatic model_cycle();
        int unsigned cnt;
        logic        ev, erdy, pop, push;
        logic [31:0] epc, einst;
        logic [71:0] exp;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            cnt  = mq[k].size();
            erdy = (cnt != DEPTH);
            if (cnt > 0) begin
                ev = 1'b1; {epc, einst} = mq[k][0];
            end else if (k == 1 && !bus0.flush && bus0.in_valid) begin
                ev = 1'b1; epc = bus0.in_pc; einst = bus0.in_inst;
            end else begin
                ev = 1'b0; epc = '0; einst = NOP;
            end
            exp = {ev, erdy, epc, einst, 3'(cnt), 3'(mdrop[k])};
            checks++;
            if (observe(k) !== exp) begin
                errors++;
                $display("FAIL model dut%0d t=%0t got=%h exp=%h", k, $time, observe(k), exp);
            end
            pop  = ev & bus0.out_ready;
            push = bus0.in_valid & erdy;
            if (bus0.flush) begin
                mdrop[k] = cnt - 32'(pop);
                mq[k].delete();
            end else begin
                if (pop && cnt > 0) void'(mq[k].pop_front());
                if (push && !(cnt == 0 && pop)) mq[k].push_back({bus0.in_pc, bus0.in_inst});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [71:0] want;
        want = {1'b0, 1'b1, 32'h0, NOP, 3'd0, 3'd0};
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (observe(k) !== want) begin
                errors++;
                $display("FAIL reset_init dut%0d got=%h exp=%h", k, observe(k), want);
            end
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b0, 1'b0);
            model_cycle();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (bus0.count !== 3'd3) begin
            errors++; $display("FAIL pre_reset_count got=%0d exp=3", bus0.count);
        end
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (observe(k) !== want) begin
                errors++;
                $display("FAIL reset_mid dut%0d got=%h exp=%h", k, observe(k), want);
            end
            mq[k].delete();
            mdrop[k] = 0;
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), $urandom, 1'b0, 1'b0);
            model_cycle();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (bus0.count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", bus0.count); end
        checks++;
        if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b exp=0", bus0.in_ready); end
        checks++;
        if (bus0.out_pc !== 32'h0) begin errors++; $display("FAIL fill_head got=%h exp=0", bus0.out_pc); end
        model_cycle();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus0.out_pc !== 32'(4 * i)) begin
                errors++; $display("FAIL drain_order got=%h exp=%h", bus0.out_pc, 32'(4 * i));
            end
            model_cycle();
        end
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        pc = 32'h200;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, pc, $urandom, 1'b1, 1'b0);
            model_cycle();
            pc += 4;
            checks++;
            if (bus0.count !== 3'd1 || bus1.count !== 3'd0) begin
                errors++;
                $display("FAIL stream_count cyc=%0d got=%0d/%0d exp=1/0", i, bus0.count, bus1.count);
            end
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        model_cycle();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), $urandom, 1'b0, 1'b0);
            model_cycle();
        end
        drive(1'b1, 32'h3F0, $urandom, 1'b1, 1'b1);
        model_cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (bus0.count !== 3'd0 || bus0.flush_drop !== 3'd2) begin
            errors++; $display("FAIL flush_state got cnt=%0d drop=%0d exp 0/2", bus0.count, bus0.flush_drop);
        end
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.out_inst !== NOP || bus0.out_pc !== 32'h0) begin
            errors++; $display("FAIL flush_bubble got v=%b inst=%h pc=%h", bus0.out_valid, bus0.out_inst, bus0.out_pc);
        end
        model_cycle();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), $urandom, 1'b0, 1'b0);
            model_cycle();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        model_cycle();
        model_cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (bus0.flush_drop !== 3'd0 || bus0.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_hold got drop=%0d rdy=%b exp 0/1", bus0.flush_drop, bus0.in_ready);
        end
        model_cycle();
    endtask

    task automatic test_wrap();
        logic [31:0] pc;
        pc = 32'h1000;
        for (int i = 0; i < 12 * DEPTH; i++) begin
            drive(($urandom % 4) != 0, pc, $urandom, 1'($urandom % 2), ($urandom % 16) == 0);
            model_cycle();
            pc += 4;
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (mq[0].size() == 0 && mq[1].size() == 0) break;
            model_cycle();
        end
        checks++;
        if (bus0.count !== 3'd0 || bus1.count !== 3'd0) begin
            errors++; $display("FAIL wrap_drain got=%0d/%0d exp=0/0", bus0.count, bus1.count);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), $urandom, 1'b0, 1'b0);
            model_cycle();
        end
        drive(1'b1, 32'h510, $urandom, 1'b1, 1'b0);
        checks++;
        if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", bus0.in_ready); end
        model_cycle();
        checks++;
        if (bus0.count !== 3'd3 || bus1.count !== 3'd3) begin
            errors++; $display("FAIL full_pop got=%0d/%0d exp=3/3", bus0.count, bus1.count);
        end
        drive(1'b1, 32'h510, $urandom, 1'b0, 1'b0);
        model_cycle();
        checks++;
        if (bus0.count !== 3'd4 || bus1.count !== 3'd4) begin
            errors++; $display("FAIL full_repush got=%0d/%0d exp=4/4", bus0.count, bus1.count);
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) model_cycle();
    endtask

    initial begin
        mdrop[0] = 0;
        mdrop[1] = 0;
        test_reset();
        test_fill();
        test_stream();
        test_flush();
        test_wrap();
        test_full_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
